// File: rtl/riscv_dmem_responder_pkg.sv
// rtl/riscv_dmem_responder_pkg.sv - shared configuration and FSM encoding for the dmem responder
package riscv_dmem_responder_pkg;

  localparam int CFG_XLEN          = 32;
  localparam int CFG_DMEM_ADDR_BIT = 12;
  localparam int DMEM_WAIT_W       = 4;

  typedef enum logic [1:0] {
    DMEM_RSP_IDLE = 2'd0,
    DMEM_RSP_BUSY = 2'd1,
    DMEM_RSP_RESP = 2'd2
  } dmem_rsp_state_e;

endpackage

// File: rtl/riscv_dmem.sv
// rtl/riscv_dmem.sv - word-indexed storage array with byte-lane synchronous write
module riscv_dmem #(
  parameter int XLEN   = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  word_idx,
  input  logic [XLEN/8-1:0] byte_sel,
  input  logic [XLEN-1:0]   wr_data,
  output logic [XLEN-1:0]   rd_data
);

  logic [XLEN-1:0] mem [2**IDX_W];

  // Byte-lane write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (byte_sel[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[word_idx];

endmodule

// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - dmem slave with configurable wait states and response handshake
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int XLEN          = CFG_XLEN,
  parameter int DMEM_ADDR_BIT = CFG_DMEM_ADDR_BIT,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_dmem_req_valid,
  output logic              o_dmem_req_ready,
  input  logic [XLEN-1:0]   i_dmem_req_addr,
  input  logic              i_dmem_req_wen,
  input  logic [XLEN-1:0]   i_dmem_req_wr_data,
  input  logic [XLEN/8-1:0] i_dmem_req_byte_sel,
  output logic              o_dmem_rsp_valid,
  output logic [XLEN-1:0]   o_dmem_rsp_rd_data,
  output logic              o_dmem_rsp_err,
  input  logic              i_dmem_rsp_ready
);

  localparam int IDX_W = DMEM_ADDR_BIT - 2;
  localparam logic [DMEM_WAIT_W-1:0] WAIT_INIT = DMEM_WAIT_W'(WAIT_CYCLES);

  dmem_rsp_state_e         state_q, state_d;
  logic [DMEM_WAIT_W-1:0]  cnt_q;
  logic [XLEN-3:0]         word_addr_q;
  logic                    wen_q;
  logic [XLEN-1:0]         wr_data_q;
  logic [XLEN/8-1:0]       byte_sel_q;

  logic                    accept;
  logic                    enter_resp;
  logic [XLEN-3:0]         sel_word;
  logic                    sel_wen;
  logic [XLEN-1:0]         sel_wr_data;
  logic [XLEN/8-1:0]       sel_byte_sel;
  logic                    addr_err;
  logic                    mem_we;
  logic [XLEN-1:0]         mem_rd_data;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = &{1'b0, i_dmem_req_addr[1:0]};

  assign o_dmem_req_ready = (state_q == DMEM_RSP_IDLE);
  assign accept           = o_dmem_req_ready && i_dmem_req_valid;

  // With zero wait states the commit happens on the accept edge, so the
  // storage must see the live request rather than the not-yet-latched copy.
  assign sel_word     = (state_q == DMEM_RSP_IDLE) ? i_dmem_req_addr[XLEN-1:2] : word_addr_q;
  assign sel_wen      = (state_q == DMEM_RSP_IDLE) ? i_dmem_req_wen            : wen_q;
  assign sel_wr_data  = (state_q == DMEM_RSP_IDLE) ? i_dmem_req_wr_data        : wr_data_q;
  assign sel_byte_sel = (state_q == DMEM_RSP_IDLE) ? i_dmem_req_byte_sel       : byte_sel_q;
  assign addr_err     = |sel_word[XLEN-3:IDX_W];
  assign mem_we       = enter_resp && sel_wen && !addr_err;

  // Next-state logic and detection of the edge that commits/reads storage.
  always_comb begin
    state_d    = state_q;
    enter_resp = 1'b0;
    case (state_q)
      DMEM_RSP_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = DMEM_RSP_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = DMEM_RSP_BUSY;
          end
        end
      end
      DMEM_RSP_BUSY: begin
        if (cnt_q == DMEM_WAIT_W'(1)) begin
          state_d    = DMEM_RSP_RESP;
          enter_resp = 1'b1;
        end
      end
      DMEM_RSP_RESP: begin
        if (i_dmem_rsp_ready) state_d = DMEM_RSP_IDLE;
      end
      default: state_d = DMEM_RSP_IDLE;
    endcase
  end

  // State, wait counter, request latch and response register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q            <= DMEM_RSP_IDLE;
      cnt_q              <= '0;
      word_addr_q        <= '0;
      wen_q              <= 1'b0;
      wr_data_q          <= '0;
      byte_sel_q         <= '0;
      o_dmem_rsp_valid   <= 1'b0;
      o_dmem_rsp_rd_data <= '0;
      o_dmem_rsp_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q       <= WAIT_INIT;
        word_addr_q <= i_dmem_req_addr[XLEN-1:2];
        wen_q       <= i_dmem_req_wen;
        wr_data_q   <= i_dmem_req_wr_data;
        byte_sel_q  <= i_dmem_req_byte_sel;
      end else if (state_q == DMEM_RSP_BUSY) begin
        cnt_q <= cnt_q - DMEM_WAIT_W'(1);
      end
      if (enter_resp) begin
        o_dmem_rsp_valid   <= 1'b1;
        o_dmem_rsp_rd_data <= (sel_wen || addr_err) ? '0 : mem_rd_data;
        o_dmem_rsp_err     <= addr_err;
      end else if (o_dmem_rsp_valid && i_dmem_rsp_ready) begin
        o_dmem_rsp_valid   <= 1'b0;
        o_dmem_rsp_rd_data <= '0;
        o_dmem_rsp_err     <= 1'b0;
      end
    end
  end

  riscv_dmem #(
    .XLEN  (XLEN),
    .IDX_W (IDX_W)
  ) u_dmem (
    .clk      (i_clk),
    .we       (mem_we),
    .word_idx (sel_word[IDX_W-1:0]),
    .byte_sel (sel_byte_sel),
    .wr_data  (sel_wr_data),
    .rd_data  (mem_rd_data)
  );

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb/tb_riscv_dmem_responder.sv - directed self-checking bench for the dmem responder
module tb_riscv_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wr_data = '0;
  logic [3:0]  req_byte_sel = '0;

  logic        rv = 1'b0, rr = 1'b0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rd_data;

  logic        rv0 = 1'b0, rr0 = 1'b0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rd_data0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  always #5 clk = ~clk;

  riscv_dmem_responder #(.WAIT_CYCLES(2)) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_dmem_req_valid(rv), .o_dmem_req_ready(req_ready),
    .i_dmem_req_addr(req_addr), .i_dmem_req_wen(req_wen),
    .i_dmem_req_wr_data(req_wr_data), .i_dmem_req_byte_sel(req_byte_sel),
    .o_dmem_rsp_valid(rsp_valid), .o_dmem_rsp_rd_data(rsp_rd_data),
    .o_dmem_rsp_err(rsp_err), .i_dmem_rsp_ready(rr)
  );

  riscv_dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rstn(rst_n),
    .i_dmem_req_valid(rv0), .o_dmem_req_ready(req_ready0),
    .i_dmem_req_addr(req_addr), .i_dmem_req_wen(req_wen),
    .i_dmem_req_wr_data(req_wr_data), .i_dmem_req_byte_sel(req_byte_sel),
    .o_dmem_rsp_valid(rsp_valid0), .o_dmem_rsp_rd_data(rsp_rd_data0),
    .o_dmem_rsp_err(rsp_err0), .i_dmem_rsp_ready(rr0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction on dut (sel=0) or dut0 (sel=1); lat counts the accept edge as 1.
  task automatic txn(input bit sel, input logic [31:0] addr, input logic wen,
                     input logic [31:0] wdata, input logic [3:0] bsel,
                     output logic [31:0] rdata, output logic err, output int l);
    req_addr = addr; req_wen = wen; req_wr_data = wdata; req_byte_sel = bsel;
    if (sel) rv0 = 1'b1; else rv = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0; rv0 = 1'b0;
    l = 1;
    while (!(sel ? rsp_valid0 : rsp_valid) && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    rdata = sel ? rsp_rd_data0 : rsp_rd_data;
    err   = sel ? rsp_err0 : rsp_err;
    if (sel) rr0 = 1'b1; else rr = 1'b1;
    @(posedge clk); #1;
    rr = 1'b0; rr0 = 1'b0;
  endtask

  initial begin
    // Reset asserted between edges: outputs must settle without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rd_data", rsp_rd_data, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write then read with two wait states.
    txn(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'b1111, rd, er, lat);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_err", 32'(er), 32'd0);
    check("wr_rd_data_zero", rd, 32'h0);
    txn(0, 32'h10, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_data_full", rd, 32'hDEADBEEF);
    check("rd_err", 32'(er), 32'd0);

    // Single-lane write.
    txn(0, 32'h10, 1'b1, 32'h0000AA00, 4'b0010, rd, er, lat);
    txn(0, 32'h10, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("rd_partial", rd, 32'hDEADAAEF);

    // Write with no lanes enabled still responds and leaves memory alone.
    txn(0, 32'h10, 1'b1, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    check("bsel0_lat", 32'(lat), 32'd3);
    txn(0, 32'h10, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("bsel0_unchanged", rd, 32'hDEADAAEF);

    // Backpressure: response held, a pending new request must not be accepted.
    req_addr = 32'h10; req_wen = 1'b0; rv = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("bp_valid_rise", 32'(rsp_valid), 32'd1);
    req_addr = 32'h30; req_wen = 1'b1; req_wr_data = 32'h55AA55AA; req_byte_sel = 4'hF;
    rv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_data_hold", rsp_rd_data, 32'hDEADAAEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rr = 1'b1;
    @(posedge clk); #1;
    rr = 1'b0;
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_valid_clr", 32'(rsp_valid), 32'd0);
    check("bp_data_clr", rsp_rd_data, 32'h0);
    @(posedge clk); #1;
    rv = 1'b0;
    req_wr_data = 32'h0;
    check("bp_accepted", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk); #1;
    check("bp_wr_valid", 32'(rsp_valid), 32'd1);
    check("bp_wr_err", 32'(rsp_err), 32'd0);
    rr = 1'b1;
    @(posedge clk); #1;
    rr = 1'b0;
    txn(0, 32'h30, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("bp_wr_readback", rd, 32'h55AA55AA);

    // Out-of-range write aliases word 0 if the range check is broken.
    txn(0, 32'h0, 1'b1, 32'h0BADC0DE, 4'hF, rd, er, lat);
    txn(0, 32'h1000, 1'b1, 32'h12345678, 4'hF, rd, er, lat);
    check("oor_wr_err", 32'(er), 32'd1);
    check("oor_wr_data", rd, 32'h0);
    txn(0, 32'h0, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("oor_word0_kept", rd, 32'h0BADC0DE);
    check("oor_word0_err", 32'(er), 32'd0);
    txn(0, 32'h2010, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("oor_rd_err", 32'(er), 32'd1);
    check("oor_rd_data", rd, 32'h0);

    // Reset during BUSY drops the pending write.
    txn(0, 32'h20, 1'b1, 32'hCAFEF00D, 4'hF, rd, er, lat);
    req_addr = 32'h20; req_wen = 1'b1; req_wr_data = 32'h11111111; req_byte_sel = 4'hF;
    rv = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0;
    check("busy_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("busy_rst_ready", 32'(req_ready), 32'd1);
    check("busy_rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 32'h20, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("busy_rst_dropped", rd, 32'hCAFEF00D);

    // Reset during RESP keeps the already committed write.
    req_addr = 32'h40; req_wen = 1'b1; req_wr_data = 32'h77777777; req_byte_sel = 4'hF;
    rv = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("resp_valid", 32'(rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("resp_rst_valid", 32'(rsp_valid), 32'd0);
    check("resp_rst_ready", 32'(req_ready), 32'd1);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 32'h40, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("resp_rst_kept", rd, 32'h77777777);

    // Zero wait states: response valid on the accept edge.
    txn(1, 32'h50, 1'b1, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    check("w0_wr_lat", 32'(lat), 32'd1);
    txn(1, 32'h50, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("w0_rd_lat", 32'(lat), 32'd1);
    check("w0_rd_data", rd, 32'hA5A5A5A5);
    txn(1, 32'h2000, 1'b0, 32'h0, 4'b0, rd, er, lat);
    check("w0_oor_err", 32'(er), 32'd1);
    check("w0_ready_idle", 32'(req_ready0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
